// File: rtl/xbox_row_fetch_if.sv
// Memory read bus and vector output stream of xbox_row_fetch.
// master = fetch engine side, slave = memory/consumer side.
interface xbox_row_fetch_if #(
  parameter int LOG2_LINES_PER_MEM = 4
);
  logic [1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
  logic [1:0]                         xlr_mem_rd;
  logic [1:0][31:0]                   xlr_mem_be;
  logic [1:0][7:0][31:0]              xlr_mem_rdata;
  logic                               out_valid;
  logic                               out_ready;
  logic [7:0][31:0]                   out_vec_a;
  logic [7:0][31:0]                   out_vec_b;
  logic [LOG2_LINES_PER_MEM:0]        out_idx;
  logic                               out_last;

  modport master (
    output xlr_mem_addr, xlr_mem_rd, xlr_mem_be,
    input  xlr_mem_rdata,
    output out_valid, out_vec_a, out_vec_b, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  xlr_mem_addr, xlr_mem_rd, xlr_mem_be,
    output xlr_mem_rdata,
    input  out_valid, out_vec_a, out_vec_b, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/xbox_row_fetch.sv
// Fetches a run of line pairs from XBOX memories 0/1 in lockstep and streams
// them as vector beats; reads are credit-limited by the output buffer depth.
module xbox_row_fetch #(
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int BUF_DEPTH          = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LOG2_LINES_PER_MEM-1:0] base_addr_a,
  input  logic [LOG2_LINES_PER_MEM-1:0] base_addr_b,
  input  logic [LOG2_LINES_PER_MEM:0]   num_lines,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  xbox_row_fetch_if.master              bus
);
  localparam int L  = LOG2_LINES_PER_MEM;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [L:0]  MAX_LINES = {1'b1, {L{1'b0}}};
  localparam logic [CW:0] DEPTH_W   = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [L-1:0]     r_base_a, r_base_b, r_addr_a, r_addr_b;
  logic [L:0]       r_num, r_issued, r_idx;
  logic             r_inflight, r_done, r_err;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [7:0][31:0] r_buf_a [BUF_DEPTH];
  logic [7:0][31:0] r_buf_b [BUF_DEPTH];

  logic       w_accept, w_legal, w_valid, w_pop, w_last, w_credit_ok, w_issue;
  logic [CW:0] w_occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  assign w_accept = start && (r_state == S_IDLE);
  assign w_legal  = (num_lines != '0) && (num_lines <= MAX_LINES);
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid && bus.out_ready;
  assign w_last   = w_valid && (r_idx == (r_num - (L+1)'(1)));
  // A same-cycle pop frees a slot, so back-to-back reads sustain full rate.
  assign w_occ       = (CW+1)'(r_count) + (CW+1)'(r_inflight);
  assign w_credit_ok = (w_occ - (CW+1)'(w_pop)) < DEPTH_W;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = (w_accept && w_legal) ? S_FETCH : S_IDLE;
      S_FETCH: w_state_nxt = (r_issued == r_num) ? S_DRAIN : S_FETCH;
      S_DRAIN: w_state_nxt = (w_pop && w_last) ? S_IDLE : S_DRAIN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: read issue, memory strobes and stream view of the buffer
  always_comb begin
    w_issue = (r_state == S_FETCH) && (r_issued != r_num) && w_credit_ok;
    if (w_issue) begin
      bus.xlr_mem_rd      = 2'b11;
      bus.xlr_mem_be      = {2{32'hFFFF_FFFF}};
      bus.xlr_mem_addr[0] = r_base_a + r_issued[L-1:0];
      bus.xlr_mem_addr[1] = r_base_b + r_issued[L-1:0];
    end else begin
      bus.xlr_mem_rd      = 2'b00;
      bus.xlr_mem_be      = '0;
      bus.xlr_mem_addr[0] = r_addr_a;
      bus.xlr_mem_addr[1] = r_addr_b;
    end
    bus.out_valid = w_valid;
    bus.out_vec_a = r_buf_a[r_rd_ptr];
    bus.out_vec_b = r_buf_b[r_rd_ptr];
    bus.out_idx   = r_idx;
    bus.out_last  = w_last;
    busy          = (r_state != S_IDLE);
    done          = r_done;
    err           = r_err;
  end

  // Run bookkeeping, read tracking and output buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_idx      <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_accept ? !w_legal : ((r_state == S_DRAIN) && w_pop && w_last);
      if (w_accept) begin
        r_err    <= (num_lines > MAX_LINES);
        r_base_a <= base_addr_a;
        r_base_b <= base_addr_b;
        r_num    <= num_lines;
        r_issued <= '0;
        r_idx    <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + (L+1)'(1);
        r_addr_a <= bus.xlr_mem_addr[0];
        r_addr_b <= bus.xlr_mem_addr[1];
      end else begin
        r_issued <= r_issued;
      end
      // Returning data always has a free slot thanks to the issue credit.
      if (r_inflight) begin
        r_buf_a[r_wr_ptr] <= bus.xlr_mem_rdata[0];
        r_buf_b[r_wr_ptr] <= bus.xlr_mem_rdata[1];
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_idx    <= r_idx + (L+1)'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= r_count + CW'(r_inflight) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_xbox_row_fetch.sv
// Randomized self-checking bench for xbox_row_fetch against a line-address
// reference model and a synchronous two-memory model.
module tb_xbox_row_fetch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr_a, base_addr_b;
  logic [4:0] num_lines;
  logic       busy, done, err;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [7:0][31:0] mem [2][16];

  xbox_row_fetch_if #(.LOG2_LINES_PER_MEM(4)) bus ();

  xbox_row_fetch #(.LOG2_LINES_PER_MEM(4), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr_a (base_addr_a),
    .base_addr_b (base_addr_b),
    .num_lines   (num_lines),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Memory model: data for a strobed address appears the following cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus.xlr_mem_rd[i]) bus.xlr_mem_rdata[i] <= mem[i][bus.xlr_mem_addr[i]];
    end
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles from first valid
  task automatic run(input logic [3:0] ba, input logic [3:0] bb, input int n,
                     input int mode, input bit poke);
    int rcnt = 0, popped = 0, first_k = -1, last_pop_k = -1;
    bit fin = 1'b0, prev_stall = 1'b0;
    logic [255:0] prev_a = '0, prev_b = '0;
    logic [4:0]   prev_idx = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr_a = ba; base_addr_b = bb; num_lines = 5'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 99) < 60);
        default: bus.out_ready = !(k >= 2 && k <= 6);
      endcase
      if (poke) begin
        start = (k == 3);
        if (k == 3) begin
          base_addr_a = ba + 4'd7; base_addr_b = bb + 4'd3; num_lines = 5'd2;
        end
      end
      @(negedge clk);
      if (bus.out_valid && first_k < 0) begin
        first_k = k;
        check_val("first_beat_lat", 256'(k), 256'd2);
      end
      if (prev_stall) begin
        check_val("hold_valid", 256'(bus.out_valid), 256'd1);
        check_val("hold_a", bus.out_vec_a, prev_a);
        check_val("hold_b", bus.out_vec_b, prev_b);
        check_val("hold_idx", 256'(bus.out_idx), 256'(prev_idx));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_a = bus.out_vec_a; prev_b = bus.out_vec_b; prev_idx = bus.out_idx;
      if (bus.out_valid && bus.out_ready) begin
        check_val("beat_a", bus.out_vec_a, mem[0][4'(ba + popped)]);
        check_val("beat_b", bus.out_vec_b, mem[1][4'(bb + popped)]);
        check_val("beat_idx", 256'(bus.out_idx), 256'(popped));
        check_val("beat_last", 256'(bus.out_last), 256'(popped == n - 1));
        if (popped == n - 1) last_pop_k = k;
        popped++;
      end
      if (bus.xlr_mem_rd != 2'b00) begin
        check_val("rd_both", 256'(bus.xlr_mem_rd), 256'd3);
        check_val("be_ones", 256'(bus.xlr_mem_be), {192'd0, {64{1'b1}}});
        check_val("addr_a", 256'(bus.xlr_mem_addr[0]), 256'(4'(ba + rcnt)));
        check_val("addr_b", 256'(bus.xlr_mem_addr[1]), 256'(4'(bb + rcnt)));
        rcnt++;
        check_val("rd_in_range", 256'(rcnt <= n), 256'd1);
        check_val("outstanding", 256'((rcnt - popped) <= 2), 256'd1);
      end
      if (done) begin
        fin = 1'b1;
        check_val("done_beats", 256'(popped), 256'(n));
        check_val("done_timing", 256'(k), 256'(last_pop_k + 1));
        check_val("done_busy", 256'(busy), 256'd0);
        check_val("done_err", 256'(err), 256'd0);
        if (mode == 0) check_val("throughput", 256'(last_pop_k), 256'(n + 1));
      end else begin
        check_val("busy_run", 256'(busy), 256'd1);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!fin) check_val("timeout", 256'd0, 256'd1);
  endtask

  task automatic run_nop(input int n, input bit exp_err);
    @(posedge clk); #1;
    start = 1'b1; num_lines = 5'(n);
    @(negedge clk);
    check_val("nop_rd0", 256'(bus.xlr_mem_rd), 256'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_val("nop_done", 256'(done), 256'd1);
    check_val("nop_err", 256'(err), 256'(exp_err));
    check_val("nop_busy", 256'(busy), 256'd0);
    check_val("nop_rd1", 256'(bus.xlr_mem_rd), 256'd0);
    @(negedge clk);
    check_val("nop_done_pulse", 256'(done), 256'd0);
    check_val("nop_err_hold", 256'(err), 256'(exp_err));
    check_val("nop_rd2", 256'(bus.xlr_mem_rd), 256'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctrl"}, 256'({busy, done, err, bus.xlr_mem_rd, bus.out_valid, bus.out_last}), 256'd0);
    check_val({tag, "_addr"}, 256'(bus.xlr_mem_addr), 256'd0);
    check_val({tag, "_be"}, 256'(bus.xlr_mem_be), 256'd0);
    check_val({tag, "_vec_a"}, bus.out_vec_a, 256'd0);
    check_val({tag, "_vec_b"}, bus.out_vec_b, 256'd0);
    check_val({tag, "_idx"}, 256'(bus.out_idx), 256'd0);
  endtask

  initial begin
    int rcnt;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int w = 0; w < 8; w++) mem[m][a][w] = $urandom;
    rst_n = 1'b0; start = 1'b0; base_addr_a = '0; base_addr_b = '0;
    num_lines = '0; bus.out_ready = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    run(4'd2, 4'd8, 3, 0, 1'b0);
    run(4'd2, 4'd8, 3, 2, 1'b0);
    run(4'd14, 4'd5, 4, 0, 1'b0);
    run_nop(17, 1'b1);
    run_nop(0, 1'b0);
    run(4'd1, 4'd9, 6, 0, 1'b1);
    run(4'd0, 4'd15, 16, 1, 1'b0);
    for (int r = 0; r < 6; r++)
      run(4'($urandom), 4'($urandom), $urandom_range(1, 16), $urandom_range(0, 2), 1'(r & 1));

    // Reset in the middle of a fetch after two reads have gone out.
    @(posedge clk); #1;
    start = 1'b1; base_addr_a = 4'd3; base_addr_b = 4'd6; num_lines = 5'd8;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    rcnt = 0;
    for (int k = 0; k < 20 && rcnt < 2; k++) begin
      @(negedge clk);
      if (bus.xlr_mem_rd != 2'b00) rcnt++;
    end
    check_val("mid_reads", 256'(rcnt), 256'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("post_rst_quiet", 256'({done, busy, bus.out_valid, bus.xlr_mem_rd}), 256'd0);
    end
    run(4'd0, 4'd0, 2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
